// File: rtl/multi_rx_pack.sv
// multi_rx_pack: packs single-cycle beats from a slow-to-fast synchronizer
// into PACK_NUM-lane words. A partial word is flushed after TIMEOUT idle
// cycles. One completed word may wait in the accumulator (FULL) while the
// output register is stalled. Beats arriving in that state are dropped and
// reported on overflow.
module multi_rx_pack #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_NUM   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clkb,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          din,
  input  logic                           valid_in,
  input  logic                           ready_in,
  output logic [DATA_WIDTH*PACK_NUM-1:0] dout,
  output logic [PACK_NUM-1:0]            byte_en,
  output logic                           valid_out,
  output logic                           overflow
);
  localparam int CW = $clog2(PACK_NUM + 1);
  localparam int WW = DATA_WIDTH * PACK_NUM;

  logic [WW-1:0]       acc, acc_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [7:0]          idle_cnt;
  logic                full;      // acc holds a finished word awaiting the output register
  logic                out_free;
  logic                complete;  // this edge finishes a word (last beat or timeout)
  logic [PACK_NUM-1:0] mask_nxt, mask_cur;

  // Next accumulator contents, word-completion detect and lane masks
  always_comb begin
    out_free = !valid_out || ready_in;
    acc_nxt  = acc;
    for (int i = 0; i < PACK_NUM; i++)
      if (valid_in && cnt == CW'(i)) acc_nxt[i*DATA_WIDTH +: DATA_WIDTH] = din;
    cnt_nxt  = cnt + CW'(valid_in);
    complete = !full &&
               ((valid_in && cnt == CW'(PACK_NUM - 1)) ||
                (!valid_in && cnt != '0 && idle_cnt == 8'(TIMEOUT - 1)));
    for (int i = 0; i < PACK_NUM; i++) begin
      mask_nxt[i] = CW'(i) < cnt_nxt;
      mask_cur[i] = CW'(i) < cnt;
    end
  end

  // Accumulator, idle timer and output register
  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      idle_cnt  <= '0;
      full      <= 1'b0;
      dout      <= '0;
      byte_en   <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (valid_out && ready_in) valid_out <= 1'b0;
      if (full) begin
        idle_cnt <= '0;
        if (out_free) begin
          // Stalled word moves out; a beat arriving now starts the next word
          dout      <= acc;
          byte_en   <= mask_cur;
          valid_out <= 1'b1;
          full      <= 1'b0;
          acc       <= '0;
          cnt       <= '0;
          if (valid_in) begin
            acc[DATA_WIDTH-1:0] <= din;
            cnt                 <= CW'(1);
          end
        end else if (valid_in) begin
          overflow <= 1'b1;
        end
      end else if (complete) begin
        idle_cnt <= '0;
        if (out_free) begin
          dout      <= acc_nxt;
          byte_en   <= mask_nxt;
          valid_out <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc  <= acc_nxt;
          cnt  <= cnt_nxt;
          full <= 1'b1;
        end
      end else begin
        acc      <= acc_nxt;
        cnt      <= cnt_nxt;
        idle_cnt <= (cnt != '0 && !valid_in) ? idle_cnt + 8'd1 : 8'd0;
      end
    end
  end
endmodule

// File: doc/multi_rx_pack.md
MULTI_RX_PACK -- requirements
Module: multi_rx_pack

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one input beat.
REQ-002 Parameter PACK_NUM, default 4, beats per output word (range 2..16).
REQ-003 Parameter TIMEOUT, default 16, number of idle cycles before a partial word is flushed (range 2..255).
REQ-004 clkb  input  1  sole clock: the fast destination domain of the slow-to-fast multi-bit synchronizer; all logic is rising-edge.
REQ-005 rst  input  1  reset: asynchronous, active-high.
REQ-006 din  input  DATA_WIDTH  beat data from the synchronizer; sampled only when valid_in=1.
REQ-007 valid_in  input  1  single-cycle beat strobe; there is no upstream backpressure.
REQ-008 ready_in  input  1  downstream ready.
REQ-009 dout  output  DATA_WIDTH*PACK_NUM  packed word, registered.
REQ-010 byte_en  output  PACK_NUM  lane-valid mask for dout, registered.
REQ-011 valid_out  output  1  output word valid, registered.
REQ-012 overflow  output  1  one-cycle pulse when an input beat is dropped, registered.

Function
REQ-013 The block shall hold an accumulator acc, a beat count cnt (0..PACK_NUM), an idle counter idle_cnt, and one output register, giving states EMPTY (cnt=0), FILL (0<cnt<PACK_NUM) and FULL (acc complete, waiting for the output register).
REQ-014 out_free shall be defined as (!valid_out || ready_in).
REQ-015 An accepted beat shall be written to lane cnt (bits cnt*DATA_WIDTH +: DATA_WIDTH), so the first beat lands in the LSB lane, and cnt shall then increment.
REQ-016 When the beat that completes a word (cnt becomes PACK_NUM) arrives and out_free=1, that word shall load the output register on the same edge: valid_out goes high 1 cycle after the last beat, with byte_en set to all ones.
REQ-017 When the completing beat arrives and out_free=0, acc shall enter FULL.
REQ-018 In FULL with out_free=1, acc shall move to the output register and acc shall clear; if valid_in=1 on the same cycle, that beat shall go to lane 0 and cnt shall become 1, with no overflow.
REQ-019 In FULL with out_free=0 and valid_in=1, the beat shall be discarded and overflow shall pulse high for 1 cycle; acc is unchanged.
REQ-020 Timeout: in FILL, idle_cnt shall increment on every cycle with valid_in=0 and clear to 0 on valid_in=1 or on leaving FILL.
REQ-021 On the TIMEOUT-th consecutive idle cycle, the partial word shall be treated as complete:
  - it follows REQ-016/REQ-017 for timing;
  - byte_en = (1<<cnt)-1;
  - unused lanes of dout = 0.
REQ-022 While valid_out=1 and ready_in=0, dout and byte_en shall hold stable.
REQ-023 A handshake occurs on a cycle with valid_out=1 and ready_in=1; valid_out shall drop on the next edge unless a new word loads on that same edge.
REQ-024 Words shall be delivered in arrival order, with no duplication and no loss except the drops reported by REQ-019.
REQ-025 Throughput: back-to-back full words with ready_in=1 shall sustain one beat per cycle with no drops.

Reset
REQ-026 While rst=1, the following shall all be 0: dout, byte_en, valid_out, overflow, acc, cnt and idle_cnt.
REQ-027 Asserting rst mid-word shall discard partial, FULL and pending output data; the first beat after release shall land in lane 0.
REQ-028 The first edge after rst deasserts shall accept valid_in normally.

Verification
REQ-029 ready_in=1; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> valid_out=1 one cycle after 0x44, dout=0x44332211, byte_en=4'hF, overflow never high.
REQ-030 Beats 0x01, 0x02, then idle with TIMEOUT=16 -> valid_out rises after the 16th idle cycle, dout=0x00000201, byte_en=4'b0011.
REQ-031 ready_in=0; beats 0x01..0x09 -> the first word is 0x04030201 and held stable, the second word 0x08070605 sits in FULL, and 0x09 causes a 1-cycle overflow pulse. After ready_in=1 -> the two words arrive in order, and 0x09 never appears.
REQ-032 FULL with ready_in rising on the same cycle as beat 0x55 -> the FULL word transfers, 0x55 sits in lane 0 of the next word, overflow=0.
REQ-033 Two beats, then rst pulse, then beats 0xA1..0xA4 -> all outputs are 0 during reset, and the next word is 0xA4A3A2A1 with byte_en=4'hF.
REQ-034 Beats spaced every 12 cycles (synchronizer-like pulses), TIMEOUT=16 -> no timeout flush, full words only.
